// File: rtl/exu_wbck_arb.sv
// Write-back arbiter for the GPR write port: merges ALU and long-pipe results through
// one registered stage and tracks pending long-pipe destinations for dispatch hazards.
module exu_wbck_arb #(
   parameter int XLEN         = 32,
   parameter int RFIDX_WIDTH  = 5,
   parameter int RFREG_NUM    = 32,
   parameter int STARVE_LIMIT = 4
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   alu_wbck_valid,
   output logic                   alu_wbck_ready,
   input  logic [RFIDX_WIDTH-1:0] alu_wbck_idx,
   input  logic [XLEN-1:0]        alu_wbck_data,
   input  logic                   lng_wbck_valid,
   output logic                   lng_wbck_ready,
   input  logic [RFIDX_WIDTH-1:0] lng_wbck_idx,
   input  logic [XLEN-1:0]        lng_wbck_data,
   input  logic                   lng_issue_valid,
   input  logic [RFIDX_WIDTH-1:0] lng_issue_idx,
   input  logic [RFIDX_WIDTH-1:0] chk_src1_idx,
   input  logic [RFIDX_WIDTH-1:0] chk_src2_idx,
   input  logic [RFIDX_WIDTH-1:0] chk_dest_idx,
   output logic                   dep_hazard,
   output logic                   lng_busy,
   output logic                   rf_wbck_ena,
   output logic [RFIDX_WIDTH-1:0] rf_wbck_idx,
   output logic [XLEN-1:0]        rf_wbck_data
);

   localparam int SW = $clog2(STARVE_LIMIT + 1);

   logic [SW-1:0]          starve_cnt;
   logic                   starve_hit;
   logic                   grant_alu;
   logic                   grant_lng;
   logic [RFIDX_WIDTH-1:0] grant_idx;
   logic [XLEN-1:0]        grant_data;
   logic                   wr_ena_d;
   logic [RFREG_NUM-1:0]   pending;

   // Long-pipe has priority unless the ALU has already waited STARVE_LIMIT cycles.
   assign starve_hit = alu_wbck_valid & (starve_cnt == SW'(STARVE_LIMIT));
   assign grant_lng  = lng_wbck_valid & ~starve_hit;
   assign grant_alu  = alu_wbck_valid & ~grant_lng;

   assign alu_wbck_ready = grant_alu;
   assign lng_wbck_ready = grant_lng;

   // NOTE: every output of a combinational block gets a default first so no latch is inferred.
   always_comb begin
      grant_idx  = alu_wbck_idx;
      grant_data = alu_wbck_data;
      if (grant_lng) begin
         grant_idx  = lng_wbck_idx;
         grant_data = lng_wbck_data;
      end
   end

   // Writes to x0 still handshake but never reach the regfile.
   assign wr_ena_d = (grant_alu | grant_lng) & (grant_idx != '0);

   // NOTE: sequential state uses non-blocking assignments so all registers update together.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         starve_cnt <= '0;
      end else if (alu_wbck_valid & ~grant_alu) begin
         if (starve_cnt != SW'(STARVE_LIMIT)) starve_cnt <= starve_cnt + 1'b1;
      end else begin
         starve_cnt <= '0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rf_wbck_ena  <= 1'b0;
         rf_wbck_idx  <= '0;
         rf_wbck_data <= '0;
      end else begin
         rf_wbck_ena <= wr_ena_d;
         if (wr_ena_d) begin
            rf_wbck_idx  <= grant_idx;
            rf_wbck_data <= grant_data;
         end
      end
   end

   // NOTE: the scoreboard is a flop array, not RAM, so it is reset like any other state.
   // Set beats clear so a re-issue on the retiring edge keeps the entry pending.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pending <= '0;
      end else begin
         pending[0] <= 1'b0;
         for (int i = 1; i < RFREG_NUM; i++) begin
            if (lng_issue_valid && (lng_issue_idx == RFIDX_WIDTH'(i)))
               pending[i] <= 1'b1;
            else if (rf_wbck_ena && (rf_wbck_idx == RFIDX_WIDTH'(i)))
               pending[i] <= 1'b0;
         end
      end
   end

   assign dep_hazard = pending[chk_src1_idx] | pending[chk_src2_idx] | pending[chk_dest_idx];
   assign lng_busy   = |pending;

endmodule

// File: tb/tb_exu_wbck_arb.sv
// Scoreboard bench for exu_wbck_arb: a reference model predicts grants, hazards and
// regfile writes; a monitor pops expected writes whenever rf_wbck_ena is seen.
module tb_exu_wbck_arb;

   localparam int LIMIT = 4;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        alu_wbck_valid, alu_wbck_ready;
   logic [4:0]  alu_wbck_idx;
   logic [31:0] alu_wbck_data;
   logic        lng_wbck_valid, lng_wbck_ready;
   logic [4:0]  lng_wbck_idx;
   logic [31:0] lng_wbck_data;
   logic        lng_issue_valid;
   logic [4:0]  lng_issue_idx;
   logic [4:0]  chk_src1_idx, chk_src2_idx, chk_dest_idx;
   logic        dep_hazard, lng_busy;
   logic        rf_wbck_ena;
   logic [4:0]  rf_wbck_idx;
   logic [31:0] rf_wbck_data;

   typedef struct {
      logic [4:0]  idx;
      logic [31:0] data;
   } wr_t;

   wr_t        exp_q[$];
   int         total = 0;
   int         bad = 0;

   // Reference model state: which registers await a long-pipe result, how long the
   // ALU has been waiting, and which write the regfile port is presenting now.
   bit [31:0]  m_pend;
   int         m_wait;
   bit         m_out_ena;
   bit [4:0]   m_out_idx;

   exu_wbck_arb #(.XLEN(32), .RFIDX_WIDTH(5), .RFREG_NUM(32), .STARVE_LIMIT(LIMIT)) dut (
      .clk             (clk),
      .rst_n           (rst_n),
      .alu_wbck_valid  (alu_wbck_valid),
      .alu_wbck_ready  (alu_wbck_ready),
      .alu_wbck_idx    (alu_wbck_idx),
      .alu_wbck_data   (alu_wbck_data),
      .lng_wbck_valid  (lng_wbck_valid),
      .lng_wbck_ready  (lng_wbck_ready),
      .lng_wbck_idx    (lng_wbck_idx),
      .lng_wbck_data   (lng_wbck_data),
      .lng_issue_valid (lng_issue_valid),
      .lng_issue_idx   (lng_issue_idx),
      .chk_src1_idx    (chk_src1_idx),
      .chk_src2_idx    (chk_src2_idx),
      .chk_dest_idx    (chk_dest_idx),
      .dep_hazard      (dep_hazard),
      .lng_busy        (lng_busy),
      .rf_wbck_ena     (rf_wbck_ena),
      .rf_wbck_idx     (rf_wbck_idx),
      .rf_wbck_data    (rf_wbck_data)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: got=timeout exp=finish");
      $fatal(1, "watchdog expired");
   end

   task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=0x%0h exp=0x%0h at %0t", name, got, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_pend    = '0;
      m_wait    = 0;
      m_out_ena = 1'b0;
      m_out_idx = '0;
      exp_q.delete();
   endtask

   // Monitor: every write the DUT presents must match the oldest predicted write.
   initial begin
      wr_t e;
      forever begin
         @(negedge clk);
         if (rst_n && rf_wbck_ena) begin
            if (exp_q.size() == 0) begin
               check("wr_unexpected", 64'(rf_wbck_ena), 64'd0);
            end else begin
               e = exp_q.pop_front();
               check("wr_idx", 64'(rf_wbck_idx), 64'(e.idx));
               check("wr_data", 64'(rf_wbck_data), 64'(e.data));
            end
         end
      end
   end

   // One cycle: drive inputs, check combinational outputs, advance the model across the edge.
   task automatic step(input logic av, input logic [4:0] ai, input logic [31:0] ad,
                       input logic lv, input logic [4:0] li, input logic [31:0] ld,
                       input logic iv, input logic [4:0] ii,
                       input logic [4:0] s1, input logic [4:0] s2, input logic [4:0] dd);
      bit       g_lng, g_alu;
      bit [4:0] w_idx;
      wr_t      w;
      alu_wbck_valid  = av;  alu_wbck_idx = ai;  alu_wbck_data = ad;
      lng_wbck_valid  = lv;  lng_wbck_idx = li;  lng_wbck_data = ld;
      lng_issue_valid = iv;  lng_issue_idx = ii;
      chk_src1_idx    = s1;  chk_src2_idx = s2;  chk_dest_idx = dd;
      @(negedge clk);
      g_lng = lv && !(av && m_wait >= LIMIT);
      g_alu = av && !g_lng;
      check("alu_ready", 64'(alu_wbck_ready), 64'(g_alu));
      check("lng_ready", 64'(lng_wbck_ready), 64'(g_lng));
      check("dep_hazard", 64'(dep_hazard), 64'(m_pend[s1] | m_pend[s2] | m_pend[dd]));
      check("lng_busy", 64'(lng_busy), 64'(m_pend != 0));
      if (exp_q.size() > 1) begin
         check("wr_missing", 64'(exp_q.size()), 64'd1);
         void'(exp_q.pop_front());
      end
      if (m_out_ena) m_pend[m_out_idx] = 1'b0;
      if (iv && ii != 0) m_pend[ii] = 1'b1;
      w_idx     = g_lng ? li : ai;
      m_out_ena = (g_lng || g_alu) && (w_idx != 0);
      if (m_out_ena) begin
         m_out_idx = w_idx;
         w.idx     = w_idx;
         w.data    = g_lng ? ld : ad;
         exp_q.push_back(w);
      end
      if (av && !g_alu) m_wait = (m_wait < LIMIT) ? m_wait + 1 : LIMIT;
      else              m_wait = 0;
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input logic [4:0] s1);
      step(0, 0, 0, 0, 0, 0, 0, 0, s1, 0, 0);
   endtask

   task automatic rand_step();
      step(1'($urandom_range(0, 1)), 5'($urandom_range(0, 15)), $urandom,
           1'($urandom_range(0, 1)), 5'($urandom_range(0, 15)), $urandom,
           1'($urandom_range(0, 3) == 0), 5'($urandom_range(0, 15)),
           5'($urandom_range(0, 15)), 5'($urandom_range(0, 15)), 5'($urandom_range(0, 15)));
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_ena"}, 64'(rf_wbck_ena), 64'd0);
      check({tag, "_idx"}, 64'(rf_wbck_idx), 64'd0);
      check({tag, "_data"}, 64'(rf_wbck_data), 64'd0);
      check({tag, "_hazard"}, 64'(dep_hazard), 64'd0);
      check({tag, "_busy"}, 64'(lng_busy), 64'd0);
   endtask

   initial begin
      rst_n = 1'b0;
      model_reset();
      for (int i = 0; i < 3; i++) begin
         alu_wbck_valid  = 1'($urandom_range(0, 1)); alu_wbck_idx = 5'($urandom); alu_wbck_data = $urandom;
         lng_wbck_valid  = 1'($urandom_range(0, 1)); lng_wbck_idx = 5'($urandom); lng_wbck_data = $urandom;
         lng_issue_valid = 1'b1; lng_issue_idx = 5'($urandom_range(1, 31));
         chk_src1_idx = 5'($urandom); chk_src2_idx = 5'($urandom); chk_dest_idx = 5'($urandom);
         @(negedge clk);
         check_reset_outputs("rst");
      end
      @(posedge clk);
      #1;
      rst_n = 1'b1;

      step(1, 5, 32'hA5A5_A5A5, 0, 0, 0, 0, 0, 0, 0, 0);
      idle(0);

      step(1, 3, 32'h3333_0003, 1, 7, 32'h7777_0007, 0, 0, 0, 0, 0);
      step(1, 3, 32'h3333_0003, 0, 0, 0, 0, 0, 0, 0, 0);
      idle(0);

      for (int i = 0; i < LIMIT + 2; i++)
         step(1, 4, 32'h4444_0000 + i, 1, 8, 32'h8888_0000 + i, 0, 0, 0, 0, 0);
      idle(0);

      step(0, 0, 0, 0, 0, 0, 1, 10, 10, 0, 0);
      idle(10);
      step(0, 0, 0, 1, 10, 32'h1010_1010, 0, 0, 10, 0, 0);
      idle(10);
      idle(10);

      step(0, 0, 0, 0, 0, 0, 1, 12, 0, 0, 0);
      step(0, 0, 0, 1, 12, 32'h1212_1212, 0, 0, 12, 0, 0);
      step(0, 0, 0, 0, 0, 0, 1, 12, 12, 0, 0);
      step(0, 0, 0, 0, 0, 0, 0, 0, 0, 12, 0);
      step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 12);
      step(0, 0, 0, 1, 12, 32'h1212_0000, 0, 0, 12, 0, 0);
      idle(12);
      idle(12);

      step(0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0);
      step(0, 0, 0, 1, 0, 32'hDEAD_0000, 0, 0, 0, 0, 0);
      idle(0);
      idle(0);

      for (int i = 0; i < 400; i++) rand_step();

      rst_n = 1'b0;
      #1;
      check_reset_outputs("midrst");
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;

      for (int i = 0; i < 200; i++) rand_step();
      repeat (3) idle(0);
      check("wr_drain", 64'(exp_q.size()), 64'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
